// File: rtl/seq_pkg.sv
// Shared types and constants for the command sequencer and its benches.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_SNT,
    ST_WAIT_RESP,
    ST_FIN
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_NAK   = 2'd1,
    ERR_TMO   = 2'd2,
    ERR_ABORT = 2'd3
  } seq_err_t;

  localparam logic [7:0]  ACK      = 8'hA5;
  localparam logic [15:0] CAL_GYRO = 16'h2000;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous show-ahead FIFO with flush; pushes when full and pops when
// empty are dropped, and flush overrides both.
module cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/cmd_sequencer.sv
// Plays queued 16-bit commands to RemoteComm one at a time, waiting for
// cmd_snt and a response byte each, with timeout and error policy.
module cmd_sequencer
  import seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TMO_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [15:0]      load_cmd,
  output logic             full,
  output logic             empty,
  input  logic             start,
  input  logic             abort,
  input  logic             stop_on_err,
  input  logic [TMO_W-1:0] tmo_clks,
  output logic [15:0]      cmd,
  output logic             snd_cmd,
  input  logic             cmd_snt,
  input  logic             resp_rdy,
  input  logic [7:0]       resp,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] n_done,
  output logic [CNT_W-1:0] n_err,
  output logic [7:0]       last_resp
);

  seq_state_t       state, state_d;
  seq_err_t         err_q, err_kind;
  logic [15:0]      fifo_head, cmd_q;
  logic             fifo_pop, fifo_flush;
  logic [TMO_W-1:0] tmo_cnt, tmo_lat;
  logic             stop_lat;
  logic [CNT_W-1:0] n_done_q, n_err_q;
  logic [7:0]       last_resp_q;
  logic             tmo_hit;
  logic             ev_start, ev_ack, ev_err, ev_abort, take_resp, settle;

  cmd_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (load),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (load_cmd),
    .rdata (fifo_head),
    .full  (full),
    .empty (empty)
  );

  // tmo_cnt holds elapsed wait cycles minus one, so the hit lands exactly
  // tmo_clks cycles after ISSUE.
  assign tmo_hit = (tmo_lat != '0) && ((tmo_cnt + TMO_W'(1)) == tmo_lat);

  // The queue head is shown directly during ISSUE so cmd is valid alongside
  // snd_cmd; the register then holds it until the next ISSUE.
  assign cmd       = (state == ST_ISSUE) ? fifo_head : cmd_q;
  assign snd_cmd   = (state == ST_ISSUE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FIN);
  assign err_code  = err_q;
  assign n_done    = n_done_q;
  assign n_err     = n_err_q;
  assign last_resp = last_resp_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next-state and event decode; abort outranks every other event.
  always_comb begin
    state_d    = state;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    ev_start   = 1'b0;
    ev_ack     = 1'b0;
    ev_err     = 1'b0;
    err_kind   = ERR_NONE;
    ev_abort   = 1'b0;
    take_resp  = 1'b0;
    settle     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (abort) fifo_flush = 1'b1;
        else if (start) begin
          ev_start = 1'b1;
          state_d  = empty ? ST_FIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (abort) ev_abort = 1'b1;
        else begin
          fifo_pop = 1'b1;
          state_d  = ST_WAIT_SNT;
        end
      end
      ST_WAIT_SNT: begin
        if (abort) ev_abort = 1'b1;
        else if (cmd_snt) state_d = ST_WAIT_RESP;
        else if (tmo_hit) begin
          ev_err   = 1'b1;
          err_kind = ERR_TMO;
          settle   = 1'b1;
        end
      end
      ST_WAIT_RESP: begin
        if (abort) ev_abort = 1'b1;
        else if (resp_rdy) begin
          take_resp = 1'b1;
          settle    = 1'b1;
          if (resp == ACK) ev_ack = 1'b1;
          else begin
            ev_err   = 1'b1;
            err_kind = ERR_NAK;
          end
        end else if (tmo_hit) begin
          ev_err   = 1'b1;
          err_kind = ERR_TMO;
          settle   = 1'b1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (ev_abort) begin
      fifo_flush = 1'b1;
      state_d    = ST_FIN;
    end
    if (settle) begin
      if (ev_err && stop_lat) begin
        fifo_flush = 1'b1;
        state_d    = ST_FIN;
      end else begin
        state_d = empty ? ST_FIN : ST_ISSUE;
      end
    end
  end

  // Datapath: command hold, timeout counter, mode latches, status counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_q       <= '0;
      tmo_cnt     <= '0;
      tmo_lat     <= '0;
      stop_lat    <= 1'b0;
      err_q       <= ERR_NONE;
      n_done_q    <= '0;
      n_err_q     <= '0;
      last_resp_q <= '0;
    end else begin
      if (state == ST_ISSUE) begin
        cmd_q   <= fifo_head;
        tmo_cnt <= '0;
      end else if (state == ST_WAIT_SNT || state == ST_WAIT_RESP) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
      if (ev_start) begin
        stop_lat <= stop_on_err;
        tmo_lat  <= tmo_clks;
        err_q    <= ERR_NONE;
        n_done_q <= '0;
        n_err_q  <= '0;
      end
      if (take_resp) last_resp_q <= resp;
      if (ev_ack && n_done_q != '1) n_done_q <= n_done_q + CNT_W'(1);
      if (ev_err) begin
        if (n_err_q != '1) n_err_q <= n_err_q + CNT_W'(1);
        if (err_q == ERR_NONE) err_q <= err_kind;
      end
      if (ev_abort) err_q <= ERR_ABORT;
    end
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer with a hand-driven RemoteComm responder.
module tb_cmd_sequencer;
  import seq_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO_W = 24;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load = 1'b0;
  logic [15:0]      load_cmd = '0;
  logic             full, empty;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             stop_on_err = 1'b0;
  logic [TMO_W-1:0] tmo_clks = '0;
  logic [15:0]      cmd;
  logic             snd_cmd;
  logic             cmd_snt = 1'b0;
  logic             resp_rdy = 1'b0;
  logic [7:0]       resp = '0;
  logic             busy, done;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] n_done, n_err;
  logic [7:0]       last_resp;

  int n_cmp = 0;
  int n_mis = 0;
  logic [15:0] sent_q[$];

  always #5 clk = ~clk;

  cmd_sequencer #(.DEPTH(DEPTH), .TMO_W(TMO_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .load_cmd    (load_cmd),
    .full        (full),
    .empty       (empty),
    .start       (start),
    .abort       (abort),
    .stop_on_err (stop_on_err),
    .tmo_clks    (tmo_clks),
    .cmd         (cmd),
    .snd_cmd     (snd_cmd),
    .cmd_snt     (cmd_snt),
    .resp_rdy    (resp_rdy),
    .resp        (resp),
    .busy        (busy),
    .done        (done),
    .err_code    (err_code),
    .n_done      (n_done),
    .n_err       (n_err),
    .last_resp   (last_resp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_cmd(input logic [15:0] c);
    load_cmd = c;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic kick(input logic stop, input logic [TMO_W-1:0] tmo);
    stop_on_err = stop;
    tmo_clks = tmo;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Answer one command: wait for snd_cmd, ack the transfer, return a byte.
  // Returns at the negedge of the cycle following the response.
  task automatic serve(input logic [7:0] r, input logic do_push, input logic [15:0] pv);
    int i = 0;
    while (!snd_cmd && i < 50) begin
      @(negedge clk);
      i++;
    end
    check("snd_seen", snd_cmd, 1);
    if (!snd_cmd) return;
    sent_q.push_back(cmd);
    @(negedge clk);
    if (do_push) begin
      load_cmd = pv;
      load = 1'b1;
    end
    @(negedge clk);
    load = 1'b0;
    cmd_snt = 1'b1;
    @(negedge clk);
    cmd_snt = 1'b0;
    check("cmd_hold", cmd, sent_q[$]);
    @(negedge clk);
    resp = r;
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (!done && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", done, 1);
  endtask

  task automatic after_done;
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("done_single", done, 0);
  endtask

  initial begin
    int c;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_cmd", cmd, 16'h0000);
    check("rst_snd", snd_cmd, 0);
    check("rst_done", done, 0);
    check("rst_err", err_code, 0);
    check("rst_ndone", n_done, 0);
    check("rst_nerr", n_err, 0);
    check("rst_last", last_resp, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // empty start: done next cycle, no error
    kick(1'b0, '0);
    check("empty_start_done", done, 1);
    check("empty_start_err", err_code, 0);
    check("empty_start_snd", snd_cmd, 0);
    after_done();

    // two commands, both ACKed
    push_cmd(CAL_GYRO);
    push_cmd(16'h47F3);
    sent_q.delete();
    kick(1'b0, '0);
    check("t1_snd_latency", snd_cmd, 1);
    check("t1_cmd_first", cmd, CAL_GYRO);
    serve(ACK, 1'b0, 16'h0);
    serve(ACK, 1'b0, 16'h0);
    wait_done(10, c);
    check("t1_done_latency", c, 0);
    check("t1_sent_cnt", sent_q.size(), 2);
    check("t1_sent0", sent_q[0], CAL_GYRO);
    check("t1_sent1", sent_q[1], 16'h47F3);
    check("t1_ndone", n_done, 2);
    check("t1_nerr", n_err, 0);
    check("t1_err", err_code, 0);
    after_done();

    // NAK on second of three, stop on error
    push_cmd(16'h1111);
    push_cmd(16'h2222);
    push_cmd(16'h3333);
    sent_q.delete();
    kick(1'b1, '0);
    serve(ACK, 1'b0, 16'h0);
    serve(8'h5A, 1'b0, 16'h0);
    wait_done(10, c);
    check("t2_done_latency", c, 0);
    check("t2_sent_cnt", sent_q.size(), 2);
    check("t2_ndone", n_done, 1);
    check("t2_nerr", n_err, 1);
    check("t2_err", err_code, 1);
    check("t2_empty", empty, 1);
    check("t2_last", last_resp, 8'h5A);
    after_done();

    // same stimulus, continue on error
    push_cmd(16'h1111);
    push_cmd(16'h2222);
    push_cmd(16'h3333);
    sent_q.delete();
    kick(1'b0, '0);
    serve(ACK, 1'b0, 16'h0);
    serve(8'h5A, 1'b0, 16'h0);
    serve(ACK, 1'b0, 16'h0);
    wait_done(10, c);
    check("t3_sent_cnt", sent_q.size(), 3);
    check("t3_sent2", sent_q[2], 16'h3333);
    check("t3_ndone", n_done, 2);
    check("t3_nerr", n_err, 1);
    check("t3_err", err_code, 1);
    check("t3_last", last_resp, ACK);
    after_done();

    // timeout of 100 cycles: done one cycle after the hit
    push_cmd(16'h47F3);
    kick(1'b1, 24'd100);
    check("t4_snd", snd_cmd, 1);
    c = 0;
    while (!done && c < 200) begin
      cmd_snt = (c == 2);
      @(negedge clk);
      c++;
    end
    cmd_snt = 1'b0;
    check("t4_done_cycle", c, 101);
    check("t4_err", err_code, 2);
    check("t4_nerr", n_err, 1);
    check("t4_ndone", n_done, 0);
    after_done();

    // timeout disabled: waits until abort
    push_cmd(16'h1234);
    kick(1'b1, '0);
    c = 0;
    while (!done && c < 300) begin
      cmd_snt = (c == 2);
      @(negedge clk);
      c++;
    end
    cmd_snt = 1'b0;
    check("t4b_no_tmo_done", done, 0);
    check("t4b_still_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t4b_abort_done", done, 1);
    check("t4b_abort_err", err_code, 3);
    check("t4b_abort_empty", empty, 1);
    after_done();

    // fill queue, drop overflow, push during a run
    for (int i = 0; i < DEPTH; i++) push_cmd(16'hA000 + 16'(i));
    check("t5_full", full, 1);
    check("t5_not_empty", empty, 0);
    push_cmd(16'hDEAD);
    check("t5_full_after_extra", full, 1);
    sent_q.delete();
    kick(1'b0, '0);
    serve(ACK, 1'b1, 16'hBEEF);
    check("t5_full_after_busy_push", full, 1);
    for (int i = 0; i < DEPTH; i++) serve(ACK, 1'b0, 16'h0);
    wait_done(10, c);
    check("t5_sent_cnt", sent_q.size(), DEPTH + 1);
    check("t5_sent0", sent_q[0], 16'hA000);
    check("t5_sent3", sent_q[3], 16'hA003);
    check("t5_sent4", sent_q[4], 16'hBEEF);
    check("t5_ndone", n_done, DEPTH + 1);
    check("t5_empty", empty, 1);
    after_done();

    // abort in IDLE flushes only
    push_cmd(16'h5555);
    push_cmd(16'h6666);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t6_idle_abort_empty", empty, 1);
    check("t6_idle_abort_done", done, 0);
    check("t6_idle_abort_busy", busy, 0);
    @(negedge clk);
    check("t6_idle_abort_done2", done, 0);

    // reset while in WAIT_RESP
    push_cmd(16'h7001);
    push_cmd(16'h7002);
    kick(1'b0, '0);
    serve(ACK, 1'b0, 16'h0);
    check("t7_second_snd", snd_cmd, 1);
    @(negedge clk);
    cmd_snt = 1'b1;
    @(negedge clk);
    cmd_snt = 1'b0;
    check("t7_pre_busy", busy, 1);
    check("t7_pre_ndone", n_done, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t7_busy", busy, 0);
    check("t7_snd", snd_cmd, 0);
    check("t7_empty", empty, 1);
    check("t7_ndone", n_done, 0);
    check("t7_nerr", n_err, 0);
    check("t7_last", last_resp, 8'h00);
    check("t7_cmd", cmd, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/cmd_sequencer.md
# cmd_sequencer

Queued command player sitting on the host side of `RemoteComm`. It generalises the single send/acknowledge/timeout flow used in bring-up into a parametrised, synthesisable engine: up to `DEPTH` 16-bit Knight commands (e.g. `CAL_GYRO`, `16'h47F3` move-south-3) are loaded, then issued back-to-back. Each command waits for `cmd_snt` and then one response byte, with a programmable timeout and a selectable stop-on-error or continue mode. It drives `RemoteComm`'s `cmd`/`snd_cmd` and consumes `cmd_snt`/`resp_rdy`/`resp`.

## Interface
Parameters:
- `DEPTH`, 8: command queue depth; power of two, ≥2.
- `TMO_W`, 24: timeout counter width.
- `CNT_W`, 8: width of completed/error counters; counters saturate.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `load`  in  1  push `load_cmd` into the queue; ignored when `full`.
- `load_cmd`  in  16  command to queue.
- `full`  out  1  queue holds `DEPTH` entries.
- `empty`  out  1  queue holds 0 entries.
- `start`  in  1  begin playing the queue; sampled only in IDLE.
- `abort`  in  1  cancel the sequence and flush the queue.
- `stop_on_err`  in  1  1 = halt on first error; 0 = log the error and continue. Sampled at `start`.
- `tmo_clks`  in  `TMO_W`  per-command timeout; 0 disables the timeout. Sampled at `start`.
- `cmd`  out  16  command to `RemoteComm`.
- `snd_cmd`  out  1  one-cycle send strobe to `RemoteComm`.
- `cmd_snt`  in  1  `RemoteComm` finished transmitting.
- `resp_rdy`  in  1  response byte valid.
- `resp`  in  8  response byte.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the sequence ends, for any reason.
- `err_code`  out  2  first error of the sequence: 0 none, 1 NAK, 2 timeout, 3 abort.
- `n_done`  out  `CNT_W`  commands acknowledged with `ACK`.
- `n_err`  out  `CNT_W`  commands that failed.
- `last_resp`  out  8  most recent response byte.

## Operation
- States: IDLE, ISSUE, WAIT_SNT, WAIT_RESP, FIN.
- **IDLE**
  - On `start`: clear `err_code`, `n_done`, `n_err`; latch the mode and `tmo_clks`.
  - Empty queue: go to FIN.
  - Otherwise: go to ISSUE.
- **ISSUE** (1 cycle)
  - Pop the queue head into the `cmd` register.
  - Assert `snd_cmd`.
  - Clear the timeout counter.
  - Go to WAIT_SNT.
- **WAIT_SNT**
  - `cmd_snt`: go to WAIT_RESP.
  - `resp_rdy` in this state is ignored.
- **WAIT_RESP**
  - On `resp_rdy`: latch `last_resp`.
    - `resp == ACK`: increment `n_done`.
    - Otherwise: NAK error.
  - Then go to ISSUE if the queue is non-empty, else FIN.
- **Timeout**
  - Counter runs through WAIT_SNT and WAIT_RESP.
  - When the counter reaches `tmo_clks` (non-zero), raise a timeout error.
- **Error handling**
  - Increment `n_err`.
  - Set `err_code` only if it is currently 0.
  - `stop_on_err` = 1: flush the queue, go to FIN.
  - `stop_on_err` = 0: continue as on a normal response.
- **Abort** (any non-IDLE state)
  - Flush the queue, set `err_code` = 3 (overrides), go to FIN.
  - Abort in IDLE flushes the queue only; no `done`.
- **FIN**: pulse `done`, return to IDLE.
- **Loading while busy** is legal; the pushed entry is played in the same sequence.
  - Push and pop in the same cycle: occupancy unchanged.
- `cmd` holds its value from ISSUE until the next ISSUE. `RemoteComm` requires `cmd` stable while transmitting.

## Timing
- Reset values:
  - State IDLE.
  - Queue empty: `empty` = 1, `full` = 0.
  - `cmd`=16'h0000, `snd_cmd`=0, `busy`=0, `done`=0, `err_code`=0, `n_done`=0, `n_err`=0, `last_resp`=8'h00.
- `start` → `snd_cmd`: 1 cycle later (ISSUE), with `cmd` valid in the same cycle.
- `resp_rdy` in WAIT_RESP → next `snd_cmd`: 1 cycle later (ISSUE).
- Final response → `done`: 1 cycle later (FIN), then `busy` low on the next cycle.
- Empty start: `done` 1 cycle after `start`, `err_code` 0.
- Timeout fires on the cycle the count equals `tmo_clks`. A `resp_rdy` in that same cycle takes priority as a valid response.
- Abort takes priority over `resp_rdy`, `cmd_snt` and timeout in the same cycle.
- `rst_n` low mid-sequence returns everything to reset values on the next edge; a `RemoteComm` transfer in flight is not tracked.
- Counters saturate at all-ones.

## Structure
- Package `seq_pkg`:
  - `seq_state_t` enum.
  - `seq_err_t` enum (NONE, NAK, TMO, ABORT).
  - `ACK` = 8'hA5.
  - Command constants shared with the benches (`CAL_GYRO`).
- Sub-module `cmd_fifo`:
  - Synchronous FIFO, parameters `DEPTH`/`WIDTH`.
  - Ports: push, pop, flush, `full`/`empty`.
  - Write-before-read is not required: pop returns the old head.

## Test plan
- Load `CAL_GYRO`, `16'h47F3`; `start`; model returns A5 to each → two `snd_cmd` pulses in order, `n_done`=2, `err_code`=0, one `done` pulse.
- Three commands, second answered 8'h5A, `stop_on_err`=1 → third never sent, `n_err`=1, `err_code`=1, `empty`=1 after `done`.
- Same stimulus with `stop_on_err`=0 → three commands sent, `n_done`=2, `n_err`=1, `last_resp`=A5.
- `tmo_clks`=100, no `resp_rdy` → error on cycle 100 after ISSUE, `err_code`=2; with `tmo_clks`=0 → waits indefinitely until `abort`, then `err_code`=3.
- Fill to `DEPTH`, push again → `full`=1, extra push dropped; push during a run → played before `done`.
- Assert `rst_n` low in WAIT_RESP → next cycle `busy`=0, `snd_cmd`=0, `empty`=1, counters 0.
